// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 2-cycle-latency instruction RAM and tags returns.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter int          ADDR_WIDTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  reloj,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_enable,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [31:0]           mem_dataIn,
  output logic                  mem_reset,
  input  logic [31:0]           mem_dataOut,
  output logic [31:0]           inst,
  output logic [31:0]           inst_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]           fetch_count,
  output logic [31:0]           bubble_count,
`endif
  output logic                  inst_valid
);

  logic [31:0] pc;
  logic        v1;
  logic [31:0] pc1;
  logic        v2;
  logic [31:0] pc2;

  // The RAM pipeline (array read and output register) advances only when decode is not stalled,
  // so the tag pipeline must freeze under exactly the same condition.
  assign mem_enable = ~reset & ~stall;
  assign mem_re     = ~reset & ~stall;
  assign mem_we     = 1'b0;
  assign mem_dataIn = 32'd0;
  assign mem_reset  = reset;
  assign mem_addr   = pc[ADDR_WIDTH+1:2];

  assign inst       = mem_dataOut;
  assign inst_pc    = pc2;
  assign inst_valid = v2;

  always_ff @(posedge reloj) begin
    if (reset) begin
      pc  <= RESET_PC;
      v1  <= 1'b0;
      pc1 <= 32'd0;
      v2  <= 1'b0;
      pc2 <= 32'd0;
    end else if (redirect_valid) begin
      // Both in-flight slots are dropped; pc1/pc2 are don't-care while their valids are low.
      pc <= redirect_pc & ~32'd3;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (!stall) begin
      pc  <= pc + 32'd4;
      v1  <= 1'b1;
      pc1 <= pc;
      v2  <= v1;
      pc2 <= pc1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge reloj) begin
    if (reset) begin
      fetch_count  <= 32'd0;
      bubble_count <= 32'd0;
    end else begin
      if (v2 && !stall) fetch_count <= fetch_count + 32'd1;
      if (!v2)          bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the instruction RAM and downstream-feeding the decode stage. It owns the program counter and drives the RAM's address/enable/output-register-enable ports. It tracks the RAM's fixed 2-cycle read latency (array read plus output register) with a tag pipeline and presents each returned instruction with its PC and a valid flag. Stall from decode and branch/jump redirects are supported.

## Interface
- `ADDR_WIDTH`, 4: RAM word-address width (RAM depth = 2^ADDR_WIDTH).
- `RESET_PC`, 32'h0000_0000: byte PC loaded on reset; bits [1:0] must be 0.
- `reloj` input 1: clock, all state updates on rising edge.
- `reset` input 1: reset, synchronous, active-high.
- `stall` input 1: decode cannot accept; freezes the fetch pipeline.
- `redirect_valid` input 1: load new PC and flush in-flight fetches.
- `redirect_pc` input 32: redirect target byte address; bits [1:0] ignored (treated as 0).
- `mem_addr` output ADDR_WIDTH: RAM word address = `pc[ADDR_WIDTH+1:2]`.
- `mem_enable` output 1: RAM array enable.
- `mem_re` output 1: RAM output-register enable.
- `mem_we` output 1: constant 0.
- `mem_dataIn` output 32: constant 0.
- `mem_reset` output 1: equals `reset`.
- `mem_dataOut` input 32: RAM output-register data.
- `inst` output 32: instruction, combinationally `mem_dataOut`.
- `inst_pc` output 32: byte PC of `inst`.
- `inst_valid` output 1: `inst`/`inst_pc` hold a live instruction.

## Operation
- State: `pc` (32b), stage-1 tag `v1`/`pc1`, stage-2 tag `v2`/`pc2`. `inst_valid = v2`, `inst_pc = pc2`.
- `mem_enable = mem_re = ~reset & ~stall`.
- Normal cycle (no reset, stall, or redirect): issue at `pc`; `pc <= pc + 4`; `v1 <= 1`, `pc1 <= pc`; `v2 <= v1`, `pc2 <= pc1`.
- Stall (no redirect): `pc`, `v1`, `pc1`, `v2`, `pc2` hold. The RAM holds because enable and re are 0, so `inst`, `inst_pc`, `inst_valid` are stable. Decode accepts an instruction on a cycle with `inst_valid & ~stall`.
- Redirect (priority over stall):
  - `pc <= {redirect_pc[31:2], 2'b00}`, `v1 <= 0`, `v2 <= 0`.
  - The request issued in the redirect cycle, and any stalled instruction, is discarded.
  - If `stall` is also high, the RAM stays frozen, but the tags are still cleared.
- Reset (priority over all): `pc <= RESET_PC`, `v1 = v2 = 0`, `pc1 = pc2 = 0`. The RAM output register clears via `mem_reset`.
- Wrap-around:
  - `pc` wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0).
  - `mem_addr` wraps modulo 2^ADDR_WIDTH words (PC 0x40 with ADDR_WIDTH=4 reads word 0).
- Reset mid-stall or mid-redirect: reset wins; the next cycle starts from `RESET_PC` with empty tags.

## Timing
- Reset values: `inst_valid`=0, `inst_pc`=0, `inst`=0 (RAM output reset), `mem_enable`=`mem_re`=0, `mem_reset`=1, `mem_addr`=`RESET_PC[ADDR_WIDTH+1:2]` after the first reset edge.
- Fetch latency: address issued in cycle t appears on `inst` with `inst_valid`=1 in cycle t+2 (no stalls).
- After reset deasserts (first cycle C0 with reset low): `mem_addr` = RESET_PC word; `inst_valid` first high in C2 with `inst_pc=RESET_PC`.
- Redirect asserted in cycle t:
  - `mem_addr` = target word in t+1.
  - `inst_valid` is 0 in t+1 and t+2.
  - Target instruction is valid in t+3.
- Steady-state throughput: 1 instruction/cycle; each stall cycle inserts exactly one cycle of hold, with no loss or duplication.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - Adds outputs `fetch_count` and `bubble_count` (32b each, reset to 0, wrap modulo 2^32).
  - `fetch_count` increments on each cycle with `inst_valid & ~stall`.
  - `bubble_count` increments on each non-reset cycle with `inst_valid`=0.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset, then run 6 cycles with RAM words 0..5 = 0xA0..0xA5 and RESET_PC=0 → `inst_valid` rises in C2; `inst`/`inst_pc` sequence (0xA0,0x0),(0xA1,0x4),(0xA2,0x8)…
- Stall high for 3 cycles while `inst_pc`=0x8 → `inst`=0xA2 and `inst_pc`=0x8 held for all 3 cycles; after release the next outputs are 0xC then 0x10, with no skip or repeat.
- Redirect to 0x24 (ADDR_WIDTH=4) in cycle t → `mem_addr`=9 in t+1; `inst_valid`=0 in t+1 and t+2; `inst_pc`=0x24 valid in t+3.
- Redirect together with stall, target 0x1 → the stalled instruction is dropped; first valid `inst_pc`=0x0 (low bits masked).
- Sequential run past PC 0x3C (ADDR_WIDTH=4) → PC 0x40 reads RAM word 0; `inst_pc`=0x40. Reset asserted mid-run → `inst_valid`=0 on the next cycle and the sequence restarts at RESET_PC.
- With `FETCH_PERF_CNT_EN`: 10 cycles after reset including 2 stall cycles → `fetch_count`=6, `bubble_count`=2.
